// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss-path sequencer for the 4 KB direct-mapped I-cache.
// Issues word reads for missed slots and writes formatted 53-bit lines back.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   ce, flush                  chip enable, fetch redirect (both cancel work)
//   miss_valid, miss1, miss2   lookup result for the pair at pc / pc+4
//   pc                         lookup address (bit 0 = MSB, stored as [31:0])
//   stall                      hold fetch PC
//   mem_req, mem_addr          read request / word address
//   mem_ack, mem_data          request accepted / returned word
//   fill_we, fill_index,       one-cycle cache write of
//   fill_line                  {valid, tag, data}
//   timeout_err                sticky memory timeout flag
//   refill_cnt                 number of fills performed (wraps)
//
// Optional feature macro: ICACHE_REFILL_PREFETCH_EN adds a one-word
// sequential prefetch (PF_REQ) after each completed demand sequence.
// Address bit numbering: spec bit i (MSB=0) maps to vector bit 31-i.

module icache_refill_ctrl #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        miss_valid,
    input  logic        miss1,
    input  logic        miss2,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic        fill_we,
    output logic [9:0]  fill_index,
    output logic [52:0] fill_line,
    output logic        timeout_err,
    output logic [15:0] refill_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        REQ2,
        FILL,
        RETRY
`ifdef ICACHE_REFILL_PREFETCH_EN
        ,
        PF_REQ
`endif
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    state_t      state;
    logic [31:0] addr2;
    logic        need2;
    logic        slot2;
    logic        cancel;
    logic [15:0] wait_cnt;
`ifdef ICACHE_REFILL_PREFETCH_EN
    logic [31:0] addr1;
    logic        need1;
    logic        pf;
    logic        pending;
`endif

    logic [31:0] miss_a1;
    logic [31:0] miss_a2;
    logic        start;
    logic        stop;
    logic        quit;
    logic        last_wait;
    logic        unused_pc_lo;

    assign miss_a1   = {pc[31:2], 2'b00};
    assign miss_a2   = miss_a1 + 32'd4;
    assign start     = miss_valid & (miss1 | miss2) & ce & ~flush;
    assign stop      = flush | ~ce;
    // cancel remembers a flush/ce drop seen earlier in the sequence
    assign quit      = cancel | stop;
    assign last_wait = (wait_cnt == WAIT_LAST);
    assign unused_pc_lo = &{1'b0, pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            stall       <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            fill_we     <= 1'b0;
            fill_index  <= '0;
            fill_line   <= '0;
            timeout_err <= 1'b0;
            refill_cnt  <= '0;
            addr2       <= '0;
            need2       <= 1'b0;
            slot2       <= 1'b0;
            cancel      <= 1'b0;
            wait_cnt    <= '0;
`ifdef ICACHE_REFILL_PREFETCH_EN
            addr1       <= '0;
            need1       <= 1'b0;
            pf          <= 1'b0;
            pending     <= 1'b0;
`endif
        end else begin
            fill_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
`ifdef ICACHE_REFILL_PREFETCH_EN
                        addr1 <= miss_a1;
                        need1 <= miss1;
`endif
                        addr2    <= miss_a2;
                        need2    <= miss2;
                        slot2    <= ~miss1;
                        cancel   <= 1'b0;
                        wait_cnt <= '0;
                        stall    <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_addr <= miss1 ? miss_a1 : miss_a2;
                        state    <= miss1 ? REQ1 : REQ2;
                    end
                end

                REQ1, REQ2
`ifdef ICACHE_REFILL_PREFETCH_EN
                , PF_REQ
`endif
                : begin
                    if (stop) cancel <= 1'b1;
`ifdef ICACHE_REFILL_PREFETCH_EN
                    // a demand miss arriving under a prefetch waits its turn
                    if (state == PF_REQ) begin
                        if (stop) begin
                            pending <= 1'b0;
                        end else if (start && !pending && !cancel) begin
                            addr1   <= miss_a1;
                            addr2   <= miss_a2;
                            need1   <= miss1;
                            need2   <= miss2;
                            pending <= 1'b1;
                            stall   <= 1'b1;
                        end
                    end
`endif
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        fill_we    <= 1'b1;
                        fill_index <= mem_addr[11:2];
                        fill_line  <= {1'b1, mem_addr[31:12], mem_data};
                        refill_cnt <= refill_cnt + 16'd1;
                        state      <= FILL;
                    end else if (last_wait) begin
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        cancel      <= 1'b1;
`ifdef ICACHE_REFILL_PREFETCH_EN
                        if (state == PF_REQ) begin
                            pending <= 1'b0;
                            pf      <= 1'b0;
                            stall   <= 1'b0;
                            state   <= IDLE;
                        end else
`endif
                        if (quit) begin
                            stall <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= RETRY;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                FILL: begin
`ifdef ICACHE_REFILL_PREFETCH_EN
                    if (pf) begin
                        pf      <= 1'b0;
                        pending <= 1'b0;
                        if (pending && !quit) begin
                            cancel   <= 1'b0;
                            wait_cnt <= '0;
                            slot2    <= ~need1;
                            mem_req  <= 1'b1;
                            mem_addr <= need1 ? addr1 : addr2;
                            state    <= need1 ? REQ1 : REQ2;
                        end else begin
                            stall <= 1'b0;
                            state <= IDLE;
                        end
                    end else
`endif
                    if (!slot2 && need2 && !quit) begin
                        slot2    <= 1'b1;
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= addr2;
                        state    <= REQ2;
                    end else if (quit) begin
                        stall <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= RETRY;
                    end
                end

                RETRY: begin
                    stall <= 1'b0;
`ifdef ICACHE_REFILL_PREFETCH_EN
                    if (!quit) begin
                        pf       <= 1'b1;
                        pending  <= 1'b0;
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= addr2 + 32'd4;
                        state    <= PF_REQ;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed per-cycle vector table for the refill
// sequencer plus hand-written timeout, flush, ce, reset and prefetch runs.

module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        miss_valid = 1'b0;
    logic        miss1 = 1'b0;
    logic        miss2 = 1'b0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic        fill_we;
    logic [9:0]  fill_index;
    logic [52:0] fill_line;
    logic        timeout_err;
    logic [15:0] refill_cnt;

    int n_chk = 0;
    int n_fail = 0;

`ifdef ICACHE_REFILL_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    icache_refill_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .miss_valid(miss_valid),
        .miss1(miss1),
        .miss2(miss2),
        .pc(pc),
        .flush(flush),
        .stall(stall),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_data(mem_data),
        .fill_we(fill_we),
        .fill_index(fill_index),
        .fill_line(fill_line),
        .timeout_err(timeout_err),
        .refill_cnt(refill_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        r, c, mv, m1, m2, fl, ack;
        logic [31:0] pc, d;
        logic        st, rq;
        logic [31:0] ad;
        logic        we;
        logic [9:0]  ix;
        logic [52:0] ln;
        logic        to;
        logic [15:0] cn;
    } vec_t;

    function automatic vec_t v(
        input logic r, c, mv, m1, m2, fl, ack,
        input logic [31:0] p, d,
        input logic st, rq,
        input logic [31:0] ad,
        input logic we,
        input logic [9:0] ix,
        input logic [52:0] ln,
        input logic to,
        input logic [15:0] cn
    );
        vec_t t;
        t.r = r; t.c = c; t.mv = mv; t.m1 = m1; t.m2 = m2;
        t.fl = fl; t.ack = ack; t.pc = p; t.d = d;
        t.st = st; t.rq = rq; t.ad = ad; t.we = we;
        t.ix = ix; t.ln = ln; t.to = to; t.cn = cn;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [31:0] p, input logic a, input logic b);
        miss_valid = 1'b1;
        miss1 = a;
        miss2 = b;
        pc = p;
        cyc();
        miss_valid = 1'b0;
        miss1 = 1'b0;
        miss2 = 1'b0;
    endtask

    localparam logic [31:0] D1 = 32'hDEADBEEF;
    localparam logic [31:0] D2 = 32'h12345678;
    localparam logic [31:0] D3 = 32'hCAFEF00D;
    localparam logic [31:0] D4 = 32'h0BADC0DE;

    vec_t tbl[$];

    initial begin
        int n_req;
        bit saw_we;

        cyc();
        cyc();

        // reset state, then suppressed misses (flush / ce=0 in IDLE)
        tbl.push_back(v(1,1,0,0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,1,1,0,1,0, 32'h1000,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,1,1,0,0, 32'h1000,0, 0,0,0,0,0,0,0,0));
        // miss1 at 0x1000, ack after two wait cycles
        tbl.push_back(v(0,1,1,1,0,0,0, 32'h1000,0, 1,1,32'h1000,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,0,0,0, 0,0, 1,1,32'h1000,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,0,0,0, 0,0, 1,1,32'h1000,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,0,0,1, 0,D1, 1,0,0,1,10'h000,
                        {1'b1,20'h00001,D1},0,1));
        tbl.push_back(v(0,1,0,0,0,0,0, 0,0, 1,0,0,0,0,0,0,1));
        tbl.push_back(v(0,1,0,0,0,0,0, 0,0, 0,PF,32'h1008,0,0,0,0,1));
        // both miss at 0x2FFC, zero-wait memory, index wraps 0x3FF -> 0
        tbl.push_back(v(1,1,0,0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,1,1,1,0,0, 32'h2FFC,0, 1,1,32'h2FFC,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,0,0,1, 0,D2, 1,0,0,1,10'h3FF,
                        {1'b1,20'h00002,D2},0,1));
        tbl.push_back(v(0,1,0,0,0,0,0, 0,0, 1,1,32'h3000,0,0,0,0,1));
        tbl.push_back(v(0,1,0,0,0,0,1, 0,D3, 1,0,0,1,10'h000,
                        {1'b1,20'h00003,D3},0,2));
        tbl.push_back(v(0,1,0,0,0,0,0, 0,0, 1,0,0,0,0,0,0,2));
        tbl.push_back(v(0,1,0,0,0,0,0, 0,0, 0,PF,32'h3004,0,0,0,0,2));
        // miss2 only at 0x10 -> single request to 0x14
        tbl.push_back(v(1,1,0,0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,1,0,1,0,0, 32'h10,0, 1,1,32'h14,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,0,0,1, 0,D4, 1,0,0,1,10'h005,
                        {1'b1,20'h00000,D4},0,1));
        tbl.push_back(v(0,1,0,0,0,0,0, 0,0, 1,0,0,0,0,0,0,1));
        tbl.push_back(v(0,1,0,0,0,0,0, 0,0, 0,PF,32'h18,0,0,0,0,1));

        foreach (tbl[i]) begin
            rst = tbl[i].r;
            ce = tbl[i].c;
            miss_valid = tbl[i].mv;
            miss1 = tbl[i].m1;
            miss2 = tbl[i].m2;
            flush = tbl[i].fl;
            mem_ack = tbl[i].ack;
            pc = tbl[i].pc;
            mem_data = tbl[i].d;
            cyc();
            chk($sformatf("row%0d stall", i), 64'(stall), 64'(tbl[i].st));
            chk($sformatf("row%0d mem_req", i), 64'(mem_req), 64'(tbl[i].rq));
            chk($sformatf("row%0d fill_we", i), 64'(fill_we), 64'(tbl[i].we));
            chk($sformatf("row%0d timeout", i), 64'(timeout_err),
                64'(tbl[i].to));
            chk($sformatf("row%0d refill_cnt", i), 64'(refill_cnt),
                64'(tbl[i].cn));
            if (tbl[i].rq)
                chk($sformatf("row%0d mem_addr", i), 64'(mem_addr),
                    64'(tbl[i].ad));
            if (tbl[i].we) begin
                chk($sformatf("row%0d fill_index", i), 64'(fill_index),
                    64'(tbl[i].ix));
                chk($sformatf("row%0d fill_line", i), 64'(fill_line),
                    64'(tbl[i].ln));
            end
        end
        rst = 1'b0; ce = 1'b1; miss_valid = 1'b0; miss1 = 1'b0;
        miss2 = 1'b0; flush = 1'b0; mem_ack = 1'b0;

        // timeout: ack never comes
        do_reset();
        issue(32'h40, 1'b1, 1'b0);
        n_req = 0;
        saw_we = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (mem_req) n_req++;
            if (fill_we) saw_we = 1'b1;
            cyc();
        end
        chk("tmo req_cycles", 64'(n_req), 64'd4);
        chk("tmo no_fill", 64'(saw_we), 64'd0);
        chk("tmo err_set", 64'(timeout_err), 64'd1);
        chk("tmo stall_low", 64'(stall), 64'd0);
        chk("tmo cnt", 64'(refill_cnt), 64'd0);
        do_reset();
        chk("tmo err_cleared", 64'(timeout_err), 64'd0);

        // flush during first wait: first fill happens, no second request
        do_reset();
        issue(32'h80, 1'b1, 1'b1);
        chk("fl req1", 64'(mem_req), 64'd1);
        chk("fl addr1", 64'(mem_addr), 64'h80);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl req_held", 64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        mem_data = 32'hA5A5_0001;
        cyc();
        mem_ack = 1'b0;
        chk("fl fill_we", 64'(fill_we), 64'd1);
        chk("fl fill_index", 64'(fill_index), 64'h020);
        chk("fl fill_line", 64'(fill_line),
            64'({1'b1, 20'h00000, 32'hA5A5_0001}));
        cyc();
        chk("fl stall_low", 64'(stall), 64'd0);
        n_req = 0;
        for (int k = 0; k < 4; k++) begin
            if (mem_req) n_req++;
            cyc();
        end
        chk("fl no_req2", 64'(n_req), 64'd0);

        // ce dropped while busy behaves like flush
        do_reset();
        issue(32'h200, 1'b1, 1'b1);
        ce = 1'b0;
        mem_ack = 1'b1;
        mem_data = 32'h5A5A_0002;
        cyc();
        ce = 1'b1;
        mem_ack = 1'b0;
        chk("ce fill_we", 64'(fill_we), 64'd1);
        chk("ce fill_index", 64'(fill_index), 64'h080);
        cyc();
        chk("ce stall_low", 64'(stall), 64'd0);
        chk("ce req_low", 64'(mem_req), 64'd0);

        // reset mid-handshake drops mem_req at once, no fill
        do_reset();
        issue(32'h300, 1'b1, 1'b0);
        chk("rst req_up", 64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst req_drop", 64'(mem_req), 64'd0);
        chk("rst stall_drop", 64'(stall), 64'd0);
        cyc();
        mem_ack = 1'b0;
        rst = 1'b0;
        saw_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (fill_we) saw_we = 1'b1;
            cyc();
        end
        chk("rst no_fill", 64'(saw_we), 64'd0);
        chk("rst cnt", 64'(refill_cnt), 64'd0);

`ifdef ICACHE_REFILL_PREFETCH_EN
        // prefetch of 0x108 with a demand miss at 0x200 arriving under it
        do_reset();
        issue(32'h100, 1'b1, 1'b0);
        chk("pf addr_d", 64'(mem_addr), 64'h100);
        mem_ack = 1'b1;
        mem_data = 32'h1111_0000;
        cyc();
        mem_ack = 1'b0;
        chk("pf fill_d", 64'(fill_index), 64'h040);
        cyc();
        chk("pf retry_stall", 64'(stall), 64'd1);
        cyc();
        chk("pf stall_low", 64'(stall), 64'd0);
        chk("pf req", 64'(mem_req), 64'd1);
        chk("pf addr", 64'(mem_addr), 64'h108);
        issue(32'h200, 1'b1, 1'b0);
        chk("pf pend_stall", 64'(stall), 64'd1);
        chk("pf addr_held", 64'(mem_addr), 64'h108);
        mem_ack = 1'b1;
        mem_data = 32'h2222_0000;
        cyc();
        mem_ack = 1'b0;
        chk("pf fill_pf", 64'(fill_index), 64'h042);
        cyc();
        chk("pf req_pend", 64'(mem_req), 64'd1);
        chk("pf addr_pend", 64'(mem_addr), 64'h200);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("pf fill_pend", 64'(fill_index), 64'h080);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
